jvo_pulse_sequencer: RTL and testbench

- Run controller for the 20-channel pulse-generator loop.
- Owns a double-buffered (shadow/active) bank of per-channel begin/end counts plus period length and idle levels.
- Owns the master period counter and the run gate, and sequences arm, trigger, burst of N periods and done.
- Sits between the AXI register slave (config writes, control strobes) and the io output stage, replacing switch-based enable.

---
 rtl/jvo_pulse_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_jvo_pulse_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jvo_pulse_sequencer.sv
// Run controller for the pulse-generator loop: shadow/active config banks, master period counter, run gate.
// Optional macro JVO_TRIG_SYNC_EN adds a 2-flop synchronizer in front of the trigger edge detector.
module jvo_pulse_sequencer #(
  parameter int NCH = 20,
  parameter int CW  = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cfg_wr_i,
  input  logic [5:0]    cfg_addr_i,
  input  logic [31:0]   cfg_wdata_i,
  input  logic          cfg_commit_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          trig_i,
  input  logic          trig_mode_i,
  input  logic [CW-1:0] burst_len_i,
  output logic [CW-1:0] cnt_beg_o [NCH-1:0],
  output logic [CW-1:0] cnt_end_o [NCH-1:0],
  output logic [NCH-1:0] io_init_o,
  output logic [CW-1:0] max_count_o,
  output logic [CW-1:0] count_o,
  output logic          run_o,
  output logic          period_tick_o,
  output logic [CW-1:0] periods_done_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          commit_pending_o,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [CW-1:0] ONE = CW'(1);

  state_e        state_q;
  logic [CW-1:0] count_q, periodsDone_q, maxCount_q, shMax_q, shMax_d;
  logic          run_q, tick_q, busy_q, done_q, pending_q, trigPrev_q;
  logic [CW-1:0] actBeg_q [NCH-1:0];
  logic [CW-1:0] actEnd_q [NCH-1:0];
  logic [CW-1:0] shBeg_q  [NCH-1:0];
  logic [CW-1:0] shEnd_q  [NCH-1:0];
  logic [CW-1:0] shBeg_d  [NCH-1:0];
  logic [CW-1:0] shEnd_d  [NCH-1:0];
  logic [NCH-1:0] ioInit_q, shInit_q, shInit_d;
  logic [CW-1:0] pdPlus;
  logic          commitReq, wrap, applyNow, trigSample, trigEvent;

  // Next shadow contents, so a write in the commit cycle lands in the copy.
  always_comb begin
    shBeg_d  = shBeg_q;
    shEnd_d  = shEnd_q;
    shMax_d  = shMax_q;
    shInit_d = shInit_q;
    if (cfg_wr_i) begin
      if (cfg_addr_i == 6'd40) begin
        shMax_d = CW'(cfg_wdata_i);
      end else if (cfg_addr_i == 6'd41) begin
        shInit_d = NCH'(cfg_wdata_i);
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (cfg_addr_i == 6'(c)) shBeg_d[c] = CW'(cfg_wdata_i);
          if (cfg_addr_i == 6'(c + 20)) shEnd_d[c] = CW'(cfg_wdata_i);
        end
      end
    end
  end

`ifdef JVO_TRIG_SYNC_EN
  logic [1:0] trigSync_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) trigSync_q <= 2'b00;
    else       trigSync_q <= {trigSync_q[0], trig_i};
  end
  assign trigSample = trigSync_q[1];
`else
  assign trigSample = trig_i;
`endif

  assign trigEvent = trigSample & ~trigPrev_q;
  assign commitReq = pending_q | cfg_commit_i;
  assign wrap      = (state_q == RUN) && !abort_i && (count_q == maxCount_q);
  // While running, the active bank may only change on a period boundary.
  assign applyNow  = commitReq && ((state_q != RUN) || wrap);
  assign pdPlus    = periodsDone_q + ONE;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NCH; c++) begin
        shBeg_q[c]  <= '0;
        shEnd_q[c]  <= '0;
        actBeg_q[c] <= '0;
        actEnd_q[c] <= '0;
      end
      shMax_q    <= '0;
      shInit_q   <= '0;
      maxCount_q <= '0;
      ioInit_q   <= '0;
      pending_q  <= 1'b0;
      trigPrev_q <= 1'b0;
    end else begin
      shBeg_q    <= shBeg_d;
      shEnd_q    <= shEnd_d;
      shMax_q    <= shMax_d;
      shInit_q   <= shInit_d;
      trigPrev_q <= trigSample;
      if (applyNow) begin
        actBeg_q   <= shBeg_d;
        actEnd_q   <= shEnd_d;
        maxCount_q <= shMax_d;
        ioInit_q   <= shInit_d;
        pending_q  <= 1'b0;
      end else begin
        pending_q  <= commitReq;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      count_q       <= '0;
      periodsDone_q <= '0;
      run_q         <= 1'b0;
      tick_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        run_q   <= 1'b0;
        done_q  <= 1'b0;
        busy_q  <= 1'b0;
        count_q <= '0;
      end else begin
        unique case (state_q)
          IDLE, DONE: begin
            if (start_i) begin
              done_q  <= 1'b0;
              busy_q  <= 1'b1;
              count_q <= '0;
              if (trig_mode_i) begin
                state_q <= ARMED;
              end else begin
                state_q       <= RUN;
                run_q         <= 1'b1;
                periodsDone_q <= '0;
              end
            end
          end
          ARMED: begin
            if (trigEvent) begin
              state_q       <= RUN;
              run_q         <= 1'b1;
              count_q       <= '0;
              periodsDone_q <= '0;
            end
          end
          RUN: begin
            if (wrap) begin
              count_q       <= '0;
              tick_q        <= 1'b1;
              periodsDone_q <= (&periodsDone_q) ? periodsDone_q : pdPlus;
              if ((burst_len_i != '0) && (pdPlus == burst_len_i)) begin
                state_q <= DONE;
                run_q   <= 1'b0;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end else begin
              count_q <= count_q + ONE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cnt_beg_o        = actBeg_q;
  assign cnt_end_o        = actEnd_q;
  assign io_init_o        = ioInit_q;
  assign max_count_o      = maxCount_q;
  assign count_o          = count_q;
  assign run_o            = run_q;
  assign period_tick_o    = tick_q;
  assign periods_done_o   = periodsDone_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign commit_pending_o = pending_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_jvo_pulse_sequencer.sv
// Self-checking bench for jvo_pulse_sequencer: random config traffic and bursts against an arithmetic model.
// Trigger latency expectation follows JVO_TRIG_SYNC_EN.
module tb_jvo_pulse_sequencer;

  localparam int NCH = 20;
  localparam int CW  = 32;
`ifdef JVO_TRIG_SYNC_EN
  localparam int TRIG_LAT = 3;
`else
  localparam int TRIG_LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cfgWr, cfgCommit, start, abort, trig, trigMode;
  logic [5:0]    cfgAddr;
  logic [31:0]   cfgWdata;
  logic [CW-1:0] burstLen;
  logic [CW-1:0] cntBeg [NCH-1:0];
  logic [CW-1:0] cntEnd [NCH-1:0];
  logic [NCH-1:0] ioInit;
  logic [CW-1:0] maxCount, count, periodsDone;
  logic          run, periodTick, busy, done, commitPending;
  logic [1:0]    state;

  logic [CW-1:0] sBeg [NCH];
  logic [CW-1:0] sEnd [NCH];
  logic [CW-1:0] aBeg [NCH];
  logic [CW-1:0] aEnd [NCH];
  logic [CW-1:0] sMax, aMax;
  logic [NCH-1:0] sInit, aInit;

  int checkCount = 0;
  int errorCount = 0;

  jvo_pulse_sequencer #(.NCH(NCH), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst),
    .cfg_wr_i(cfgWr), .cfg_addr_i(cfgAddr), .cfg_wdata_i(cfgWdata), .cfg_commit_i(cfgCommit),
    .start_i(start), .abort_i(abort), .trig_i(trig), .trig_mode_i(trigMode), .burst_len_i(burstLen),
    .cnt_beg_o(cntBeg), .cnt_end_o(cntEnd), .io_init_o(ioInit), .max_count_o(maxCount),
    .count_o(count), .run_o(run), .period_tick_o(periodTick), .periods_done_o(periodsDone),
    .busy_o(busy), .done_o(done), .commit_pending_o(commitPending), .state_o(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void modelWrite(input int a, input logic [31:0] d);
    if (a < NCH) sBeg[a] = d;
    else if (a >= 20 && a < 20 + NCH) sEnd[a-20] = d;
    else if (a == 40) sMax = d;
    else if (a == 41) sInit = d[NCH-1:0];
  endfunction

  function automatic void modelApply();
    for (int c = 0; c < NCH; c++) begin
      aBeg[c] = sBeg[c];
      aEnd[c] = sEnd[c];
    end
    aMax  = sMax;
    aInit = sInit;
  endfunction

  function automatic void modelReset();
    for (int c = 0; c < NCH; c++) begin
      sBeg[c] = '0;
      sEnd[c] = '0;
    end
    sMax  = '0;
    sInit = '0;
    modelApply();
  endfunction

  task automatic applyStimulus(input int addr, input logic [31:0] data, input logic wr, input logic commit);
    cfgWr     = wr;
    cfgAddr   = 6'(addr);
    cfgWdata  = data;
    cfgCommit = commit;
    if (wr) modelWrite(addr, data);
    step();
    cfgWr     = 1'b0;
    cfgCommit = 1'b0;
  endtask

  task automatic checkBanks(input string tag);
    for (int c = 0; c < NCH; c++) begin
      checkOutput({tag, " beg"}, cntBeg[c], aBeg[c]);
      checkOutput({tag, " end"}, cntEnd[c], aEnd[c]);
    end
    checkOutput({tag, " max"}, maxCount, aMax);
    checkOutput({tag, " init"}, ioInit, aInit);
  endtask

  // Burst timing from first principles: (m+1)*b run cycles, count = i mod (m+1).
  task automatic runBurst(input int m, input int b);
    int total;
    total    = (m + 1) * b;
    burstLen = CW'(b);
    trigMode = 1'b0;
    start    = 1'b1;
    step();
    start    = 1'b0;
    checkOutput("entry done cleared", done, 0);
    checkOutput("entry busy", busy, 1);
    for (int i = 0; i < total; i++) begin
      checkOutput("run count", count, i % (m + 1));
      checkOutput("run gate", run, 1);
      checkOutput("run tick", periodTick, (i > 0) && (i % (m + 1) == 0));
      checkOutput("run periods", periodsDone, i / (m + 1));
      step();
    end
    checkOutput("burst state", state, 3);
    checkOutput("burst run off", run, 0);
    checkOutput("burst done", done, 1);
    checkOutput("burst last tick", periodTick, 1);
    checkOutput("burst periods", periodsDone, b);
    checkOutput("burst count", count, 0);
    checkOutput("burst busy", busy, 0);
  endtask

  initial begin
    int m, n;
    logic [31:0] v;
    rst = 1'b1; cfgWr = 0; cfgCommit = 0; cfgAddr = '0; cfgWdata = '0;
    start = 0; abort = 0; trig = 0; trigMode = 0; burstLen = '0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset state", state, 0);
    checkOutput("reset run", run, 0);
    checkOutput("reset count", count, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset pending", commitPending, 0);
    checkBanks("reset");
    rst = 1'b0;
    step();

    applyStimulus(0, 5, 1, 0);
    applyStimulus(20, 9, 1, 0);
    applyStimulus(40, 19, 1, 0);
    checkOutput("no commit beg0", cntBeg[0], 0);
    checkOutput("no commit max", maxCount, 0);
    applyStimulus(0, 0, 0, 1);
    modelApply();
    checkOutput("idle commit pending", commitPending, 0);
    checkBanks("idle commit");
    runBurst(19, 3);

    for (int r = 0; r < 3; r++) begin
      for (int w = 0; w < 24; w++) applyStimulus($urandom_range(0, 63), $urandom, 1, 0);
      m = $urandom_range(0, 12);
      applyStimulus(40, 32'(m), 1, 1);
      modelApply();
      checkBanks("random commit");
      runBurst(m, $urandom_range(1, 4));
    end

    applyStimulus(40, 0, 1, 1);
    modelApply();
    runBurst(0, 4);
    applyStimulus(50, $urandom, 1, 0);
    applyStimulus(0, 0, 0, 1);
    modelApply();
    checkBanks("addr 50 ignored");

    applyStimulus(40, 5, 1, 1);
    modelApply();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort from done state", state, 0);
    checkOutput("abort from done flag", done, 0);
    trig = 1'b1;
    step();
    step();
    trig = 1'b0;
    repeat (4) step();
    checkOutput("trig idle ignored", state, 0);

    trigMode = 1'b1;
    burstLen = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("armed state", state, 1);
    checkOutput("armed busy", busy, 1);
    n = $urandom_range(3, 50);
    for (int i = 0; i < n; i++) begin
      start = (i == 1);
      step();
      checkOutput("armed hold", state, 1);
      checkOutput("armed run off", run, 0);
    end
    start = 1'b0;
    trig = 1'b1;
    for (int k = 1; k <= TRIG_LAT; k++) begin
      step();
      if (k < TRIG_LAT) begin
        checkOutput("trig latency wait", state, 1);
      end else begin
        checkOutput("trig run state", state, 2);
        checkOutput("trig run gate", run, 1);
        checkOutput("trig count zero", count, 0);
      end
    end
    step();
    checkOutput("trig count one", count, 1);
    trig = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort armed run", run, 0);
    checkOutput("abort armed state", state, 0);

    applyStimulus(40, 99, 1, 1);
    modelApply();
    trigMode = 1'b0;
    burstLen = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    checkOutput("count 40", count, 40);
    v = $urandom;
    applyStimulus(3, v, 1, 1);
    checkOutput("run pending set", commitPending, 1);
    checkOutput("run beg3 held", cntBeg[3], aBeg[3]);
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("start in run ignored", state, 2);
    checkOutput("start in run count", count, 42);
    applyStimulus(4, $urandom, 1, 0);
    repeat (99 - 43) step();
    checkOutput("pre wrap count", count, 99);
    checkOutput("pre wrap pending", commitPending, 1);
    checkOutput("pre wrap beg3", cntBeg[3], aBeg[3]);
    step();
    modelApply();
    checkOutput("wrap count", count, 0);
    checkOutput("wrap tick", periodTick, 1);
    checkOutput("wrap pending clr", commitPending, 0);
    checkOutput("wrap periods", periodsDone, 1);
    checkBanks("wrap commit");

    step();
    applyStimulus(5, $urandom, 1, 1);
    checkOutput("pending before abort", commitPending, 1);
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort+start state", state, 0);
    checkOutput("abort+start run", run, 0);
    checkOutput("abort+start count", count, 0);
    checkOutput("abort+start busy", busy, 0);
    checkOutput("abort keeps pending", commitPending, 1);
    checkOutput("abort keeps periods", periodsDone, 1);
    step();
    modelApply();
    checkOutput("idle apply pending", commitPending, 0);
    checkBanks("apply after abort");

    start = 1'b1;
    step();
    start = 1'b0;
    repeat (37) step();
    checkOutput("pre reset count", count, 37);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async reset count", count, 0);
    checkOutput("async reset run", run, 0);
    checkOutput("async reset state", state, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset periods", periodsDone, 0);
    checkBanks("async reset");
    step();
    rst = 1'b0;
    step();
    applyStimulus(0, 0, 0, 1);
    modelApply();
    checkBanks("shadow cleared");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
